pm_fetch_demux: RTL and testbench
=================================

PM_FETCH_DEMUX -- requirements
Module: pm_fetch_demux

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset; the ports SHALL be as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled only on rising clk.
REQ-004 en  input  1  fetch enable: level, sampled in IDLE and at instruction accept.
REQ-005 pm_data  input  4  program-memory read word for address pm_addr.
REQ-006 pm_valid  input  1  pm_data valid this cycle; memory may insert wait states.
REQ-007 instr_ack  input  1  consumer accepts the presented instruction.
REQ-008 jmp_en  input  1  next PC comes from jmp_addr, not PC+1; honoured only with an accepted instruction.
REQ-009 jmp_addr  input  4  jump target address.
REQ-010 pm_addr  output  4  program counter driven to program memory (registered).
REQ-011 opcode  output  4  demultiplexed first word of the instruction.
REQ-012 operand  output  4  demultiplexed second word, or 0 for single-word instructions.
REQ-013 instr_valid  output  1  opcode/operand hold a complete instruction.
REQ-014 busy  output  1  high in FETCH_OP, FETCH_ARG and READY.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH_OP, FETCH_ARG and READY, encoded in 2 bits.
REQ-016 IDLE: if en=1, next state FETCH_OP; otherwise stay; pm_addr unchanged.
REQ-017 FETCH_OP with pm_valid=1: opcode<=pm_data and pm_addr<=pm_addr+1.
REQ-018 FETCH_OP, continued: if pm_data[3]=1, go to FETCH_ARG; else operand<=0 and go to READY.
REQ-019 FETCH_ARG with pm_valid=1: operand<=pm_data, pm_addr<=pm_addr+1, go to READY.
REQ-020 FETCH_OP or FETCH_ARG with pm_valid=0: hold state, pm_addr and data registers.
REQ-021 READY: instr_valid=1; opcode/operand stable until accepted.
REQ-022 Accept occurs in READY when instr_ack=1; instr_valid drops the cycle after accept.
REQ-023 instr_ack outside READY SHALL be ignored.
REQ-024 On accept with jmp_en=1: pm_addr<=jmp_addr, overriding the incremented PC.
REQ-025 jmp_en without accept SHALL be ignored.
REQ-026 After accept, next state SHALL be FETCH_OP if en=1, else IDLE.
REQ-027 en deasserted mid-fetch SHALL NOT abort; the current instruction completes to READY.
REQ-028 PC arithmetic is 4-bit modulo: 4'hF+1 wraps to 4'h0, including across the two words of one instruction.
REQ-029 Latency: minimum 1 cycle from en in IDLE to FETCH_OP; instr_valid the cycle after the last pm_valid word.
REQ-030 Single-word instructions SHALL sustain one instruction per 2 cycles with pm_valid and instr_ack held high.

Reset
REQ-031 On reset, the following SHALL be set:
- state=IDLE;
- pm_addr=0, opcode=0, operand=0;
- instr_valid=0, busy=0.
REQ-032 Reset SHALL override all inputs in the same cycle.
REQ-033 Reset mid-fetch or in READY SHALL discard the partial or pending instruction.

Verification
REQ-034 Reset then en=1, memory {0:4'h2}, pm_valid=1 -> opcode=2, operand=0, instr_valid=1, pm_addr=1.
REQ-035 Two-word fetch, memory {1:4'h9, 2:4'h5}, 2 wait states on word 2 -> state held during waits; then opcode=9, operand=5, pm_addr=3.
REQ-036 instr_ack=1 and jmp_en=1 with jmp_addr=4'hC -> pm_addr=C next cycle; the next fetch reads address C.
REQ-037 pm_addr=4'hF holding 4'h8, address 0 holding 4'h3 -> opcode=8, operand=3, pm_addr=1.
REQ-038 Assert reset while in FETCH_ARG -> next cycle: all outputs 0, state IDLE, no instr_valid pulse.
REQ-039 en dropped during FETCH_OP -> instruction still presented; after accept, state IDLE and busy=0.

Source files
------------

// File: rtl/pm_fetch_demux.sv
// Fetches one- or two-word instructions from program memory and presents them as opcode/operand.
// Latency: instr_valid is registered, so it rises the cycle after the last pm_valid word is taken.
// Backpressure: waits in FETCH_* while pm_valid=0; holds the instruction in READY until instr_ack.
module pm_fetch_demux (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] pm_data,
    input  logic       pm_valid,
    input  logic       instr_ack,
    input  logic       jmp_en,
    input  logic [3:0] jmp_addr,
    output logic [3:0] pm_addr,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    output logic       instr_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_ARG = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pm_addr_q, pm_addr_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] operand_q, operand_d;
    logic       instr_valid_q, instr_valid_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        pm_addr_d = pm_addr_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH_OP;
                end
            end
            FETCH_OP: begin
                if (pm_valid) begin
                    opcode_d  = pm_data;
                    pm_addr_d = pm_addr_q + 4'd1;
                    // Opcode bit 3 marks a two-word instruction.
                    if (pm_data[3]) begin
                        state_d = FETCH_ARG;
                    end else begin
                        operand_d = 4'd0;
                        state_d   = READY;
                    end
                end
            end
            FETCH_ARG: begin
                if (pm_valid) begin
                    operand_d = pm_data;
                    pm_addr_d = pm_addr_q + 4'd1;
                    state_d   = READY;
                end
            end
            READY: begin
                if (instr_ack) begin
                    if (jmp_en) begin
                        pm_addr_d = jmp_addr;
                    end
                    state_d = en ? FETCH_OP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered from the next state so they align with it.
        instr_valid_d = (state_d == READY);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pm_addr_q     <= 4'd0;
            opcode_q      <= 4'd0;
            operand_q     <= 4'd0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pm_addr_q     <= pm_addr_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign pm_addr     = pm_addr_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pm_fetch_demux.sv
// Directed bench for pm_fetch_demux: a small program memory model feeds the fetcher,
// expected instructions are queued when set up and checked when instr_valid appears.
module tb_pm_fetch_demux;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] pm_data;
    logic       pm_valid;
    logic       instr_ack;
    logic       jmp_en;
    logic [3:0] jmp_addr;
    logic [3:0] pm_addr;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic       busy;

    logic [3:0] mem [16];

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] arg;
        logic [3:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid;

    pm_fetch_demux dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pm_data     (pm_data),
        .pm_valid    (pm_valid),
        .instr_ack   (instr_ack),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .pm_addr     (pm_addr),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .busy        (busy)
    );

    assign pm_data = mem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        chk("sb_underflow", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_opcode", 32'(opcode), 32'(e.op));
            chk("sb_operand", 32'(operand), 32'(e.arg));
            chk("sb_pm_addr", 32'(pm_addr), 32'(e.pc));
        end
    endtask

    task automatic wait_instr(input int max_cyc);
        int n = 0;
        while (instr_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", 32'(instr_valid), 32'd1);
        if (instr_valid === 1'b1) pop_check();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        // Reset must win over every active input.
        reset = 1'b1; en = 1'b1; instr_ack = 1'b1; jmp_en = 1'b1;
        jmp_addr = 4'h7; pm_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single-word fetch from address 0.
        mem[0] = 4'h2;
        reset = 1'b0; en = 1'b1; instr_ack = 1'b0; jmp_en = 1'b0; pm_valid = 1'b1;
        sb.push_back('{op: 4'h2, arg: 4'h0, pc: 4'h1});
        @(negedge clk);
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_no_valid", 32'(instr_valid), 32'd0);
        wait_instr(8);

        // Jump without accept is ignored and the instruction holds.
        jmp_en = 1'b1; jmp_addr = 4'hC;
        @(negedge clk);
        chk("jmp_no_ack_pc", 32'(pm_addr), 32'd1);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_opcode", 32'(opcode), 32'h2);
        jmp_en = 1'b0;

        // Two-word fetch with two wait states on the second word.
        mem[1] = 4'h9; mem[2] = 4'h5;
        instr_ack = 1'b1;
        @(negedge clk);
        chk("valid_drop", 32'(instr_valid), 32'd0);
        instr_ack = 1'b0;
        sb.push_back('{op: 4'h9, arg: 4'h5, pc: 4'h3});
        @(negedge clk);
        pm_valid = 1'b0;
        chk("arg_pm_addr", 32'(pm_addr), 32'h2);
        chk("arg_opcode", 32'(opcode), 32'h9);
        repeat (2) begin
            @(negedge clk);
            chk("wait_pm_addr", 32'(pm_addr), 32'h2);
            chk("wait_no_valid", 32'(instr_valid), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
        end
        pm_valid = 1'b1;
        wait_instr(8);

        // Accept with jump to C; the next fetch reads address C.
        mem[12] = 4'h1;
        instr_ack = 1'b1; jmp_en = 1'b1; jmp_addr = 4'hC;
        @(negedge clk);
        chk("jmp_pm_addr", 32'(pm_addr), 32'hC);
        instr_ack = 1'b0; jmp_en = 1'b0;
        sb.push_back('{op: 4'h1, arg: 4'h0, pc: 4'hD});
        wait_instr(8);

        // Two-word instruction straddling the F->0 wrap.
        mem[15] = 4'h8; mem[0] = 4'h3;
        instr_ack = 1'b1; jmp_en = 1'b1; jmp_addr = 4'hF;
        @(negedge clk);
        chk("jmp_f_pm_addr", 32'(pm_addr), 32'hF);
        instr_ack = 1'b0; jmp_en = 1'b0;
        sb.push_back('{op: 4'h8, arg: 4'h3, pc: 4'h1});
        wait_instr(8);

        // Back-to-back single-word instructions, one per two cycles.
        mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h6;
        sb.push_back('{op: 4'h2, arg: 4'h0, pc: 4'h2});
        sb.push_back('{op: 4'h4, arg: 4'h0, pc: 4'h3});
        sb.push_back('{op: 4'h6, arg: 4'h0, pc: 4'h4});
        instr_ack = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                n_valid++;
                pop_check();
            end
        end
        chk("throughput", 32'(n_valid), 32'd3);
        instr_ack = 1'b0;

        // en dropped during FETCH_OP: the instruction still completes.
        mem[4] = 4'h5;
        instr_ack = 1'b1; en = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0; en = 1'b0; pm_valid = 1'b0;
        @(negedge clk);
        chk("en_drop_busy", 32'(busy), 32'd1);
        pm_valid = 1'b1;
        sb.push_back('{op: 4'h5, arg: 4'h0, pc: 4'h5});
        wait_instr(8);
        instr_ack = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_valid", 32'(instr_valid), 32'd0);
        chk("idle_pm_addr", 32'(pm_addr), 32'h5);
        instr_ack = 1'b0;
        @(negedge clk);
        chk("idle_stay_busy", 32'(busy), 32'd0);

        // Reset while in FETCH_ARG discards the partial instruction.
        mem[5] = 4'hA; mem[6] = 4'h7;
        en = 1'b1; pm_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_opcode", 32'(opcode), 32'hA);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("mid_rst_opcode", 32'(opcode), 32'd0);
        chk("mid_rst_operand", 32'(operand), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
